// File: rtl/class_update_ctrl.sv
// Read-modify-write sequencer for class HVs in class memory: bundles one class
// with incoming chunks, or walks every class to binarize it.
module class_update_ctrl #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned NUM_CHUNKS  = 32,
    parameter int unsigned CLASS_W     = $clog2(NUM_CLASSES),
    parameter int unsigned CHUNK_W     = $clog2(NUM_CHUNKS),
    parameter int unsigned ADDR_W      = $clog2(NUM_CLASSES * NUM_CHUNKS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [CLASS_W-1:0] label_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    input  logic               hv_chunk_valid_i,
    output logic               hv_chunk_ready_o,
    output logic [CHUNK_W-1:0] chunk_idx_o,
    output logic               binarizing_class_hvs_o,
    output logic               mem_rd_en_o,
    output logic [ADDR_W-1:0]  mem_rd_addr_o,
    output logic               mem_wr_en_o,
    output logic [ADDR_W-1:0]  mem_wr_addr_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic               mode_q, mode_d;
    logic               err_d;
    logic               wr_d;
    logic               last_chunk;
    logic               last_class;
    logic               label_bad;
    logic [ADDR_W-1:0]  addr_d;

    assign last_chunk = (32'(chunk_q) == NUM_CHUNKS - 1);
    assign last_class = (32'(class_q) == NUM_CLASSES - 1);
    assign label_bad  = (32'(label_i) >= NUM_CLASSES);
    assign addr_d     = ADDR_W'(class_d) * ADDR_W'(NUM_CHUNKS) + ADDR_W'(chunk_d);

    // Next-state and counter update; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        chunk_d = chunk_q;
        mode_d  = mode_q;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (!mode_i && label_bad) begin
                            err_d = 1'b1;
                        end else begin
                            mode_d  = mode_i;
                            class_d = mode_i ? '0 : label_i;
                            chunk_d = '0;
                            state_d = RD;
                        end
                    end
                end
                RD: state_d = WR;
                WR: begin
                    if (hv_chunk_valid_i) begin
                        wr_d = 1'b1;
                        if (!last_chunk) begin
                            chunk_d = chunk_q + CHUNK_W'(1);
                            state_d = RD;
                        end else if (mode_q && !last_class) begin
                            chunk_d = '0;
                            class_d = class_q + CLASS_W'(1);
                            state_d = RD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Write strobe is same-cycle with the accepted chunk.
    assign mem_wr_en_o   = wr_d;
    assign mem_wr_addr_o = mem_rd_addr_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                <= IDLE;
            class_q                <= '0;
            chunk_q                <= '0;
            mode_q                 <= 1'b0;
            busy_o                 <= 1'b0;
            done_o                 <= 1'b0;
            err_o                  <= 1'b0;
            hv_chunk_ready_o       <= 1'b0;
            chunk_idx_o            <= '0;
            binarizing_class_hvs_o <= 1'b0;
            mem_rd_en_o            <= 1'b0;
            mem_rd_addr_o          <= '0;
        end else begin
            state_q                <= state_d;
            class_q                <= class_d;
            chunk_q                <= chunk_d;
            mode_q                 <= mode_d;
            busy_o                 <= (state_d != IDLE);
            done_o                 <= (state_d == DONE);
            err_o                  <= err_d;
            hv_chunk_ready_o       <= (state_d == WR);
            chunk_idx_o            <= chunk_d;
            binarizing_class_hvs_o <= mode_d;
            mem_rd_en_o            <= (state_d == RD);
            mem_rd_addr_o          <= addr_d;
        end
    end

endmodule
